// File: rtl/tone_divider.sv
// tone_divider: preset-reload tone divider producing a speaker square wave.
// Ports: CLK, RST (sync, active-high), EN (prescaler tick), TONE (preset),
//        SPKS (square wave), FULL (reload pulse), NOTE_CHG, REST.
module tone_divider #(
  parameter int WIDTH = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] TONE,
  output logic             SPKS,
  output logic             FULL,
  output logic             NOTE_CHG,
  output logic             REST
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tone_l_q, tone_l_d;
  logic             spks_q, spks_d;
  logic             full_q, full_d;
  logic             chg_q, chg_d;
  logic             rest_q, rest_d;
  logic             reload;
  logic             is_rest;

  assign reload  = EN && (cnt_q == MAXV);
  assign is_rest = (TONE == MAXV);

  always_comb begin
    cnt_d    = cnt_q;
    tone_l_d = tone_l_q;
    spks_d   = spks_q;
    full_d   = 1'b0;
    chg_d    = 1'b0;
    rest_d   = rest_q;
    if (reload) begin
      // TONE is only sampled here, so mid-period changes wait
      // for the current half-period to finish.
      cnt_d    = TONE;
      tone_l_d = TONE;
      full_d   = 1'b1;
      chg_d    = (TONE != tone_l_q);
      rest_d   = is_rest;
      spks_d   = is_rest ? 1'b0 : ~spks_q;
    end else if (EN) begin
      // cnt_q < MAXV here, so the increment cannot wrap.
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // MAXV in the counter makes the first tick after release a reload.
      cnt_q    <= MAXV;
      tone_l_q <= MAXV;
      spks_q   <= 1'b0;
      full_q   <= 1'b0;
      chg_q    <= 1'b0;
      rest_q   <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      tone_l_q <= tone_l_d;
      spks_q   <= spks_d;
      full_q   <= full_d;
      chg_q    <= chg_d;
      rest_q   <= rest_d;
    end
  end

  assign SPKS     = spks_q;
  assign FULL     = full_q;
  assign NOTE_CHG = chg_q;
  assign REST     = rest_q;

endmodule

// File: tb/tb_tone_divider.sv
// tb_tone_divider: scoreboard bench for tone_divider.
// Driver pushes model expectations; monitor pops and compares each cycle.
module tb_tone_divider;

  localparam int W = 11;
  localparam logic [W-1:0] MAXV = '1;

  logic         clk = 1'b1;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] tone = '1;
  logic         spks, full, note_chg, rest;

  tone_divider #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .EN(en), .TONE(tone),
    .SPKS(spks), .FULL(full), .NOTE_CHG(note_chg), .REST(rest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  int cyc = 0;
  int edge_q[$];
  int full_q[$];
  int chg_n = 0;
  logic prev_spk = 1'b0;

  // Reference model: ticks remaining before the next reload.
  int m_left = 0;
  logic [W-1:0] m_tone = '1;
  logic m_spk = 0, m_full = 0, m_chg = 0, m_rest = 1;

  task automatic step(input logic r, input logic e, input logic [W-1:0] t);
    @(negedge clk);
    rst = r; en = e; tone = t;
    if (r) begin
      m_left = 0; m_tone = MAXV;
      m_spk = 0; m_full = 0; m_chg = 0; m_rest = 1;
    end else if (e) begin
      if (m_left == 0) begin
        m_full = 1;
        m_chg  = (t != m_tone);
        m_tone = t;
        m_rest = (t == MAXV);
        m_spk  = m_rest ? 1'b0 : !m_spk;
        m_left = int'(MAXV) - int'(t);
      end else begin
        m_left = m_left - 1;
        m_full = 0; m_chg = 0;
      end
    end else begin
      m_full = 0; m_chg = 0;
    end
    exp_q.push_back({m_spk, m_full, m_chg, m_rest});
  endtask

  // Wait until the edge of the last driven step has been observed.
  task automatic clr();
    @(posedge clk); #2;
    edge_q.delete();
    full_q.delete();
  endtask

  task automatic check_gaps(input bit use_full, input int stride,
                            input int gap, input int min_n,
                            input string nm);
    int q[$];
    if (use_full) q = full_q;
    else q = edge_q;
    n_cmp++;
    if (q.size() < min_n) begin
      n_bad++;
      $display("FAIL %s count got %0d need >= %0d", nm, q.size(), min_n);
    end
    for (int i = 0; i + stride < q.size(); i++) begin
      n_cmp++;
      if (q[i+stride] - q[i] != gap) begin
        n_bad++;
        $display("FAIL %s gap[%0d] got %0d want %0d",
                 nm, i, q[i+stride] - q[i], gap);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        n_cmp++;
        if ({spks, full, note_chg, rest} !== mon_exp) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d spks,full,chg,rest got %b want %b",
                   cyc, {spks, full, note_chg, rest}, mon_exp);
        end
      end
      if (spks !== prev_spk) edge_q.push_back(cyc);
      prev_spk = spks;
      if (full === 1'b1) full_q.push_back(cyc);
      if (note_chg === 1'b1) chg_n++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  int chg0;
  logic [W-1:0] rt;

  initial begin
    // Reset then steady 7FC: FULL every 4, SPKS period 8.
    step(1, 1, 11'h7FC);
    step(1, 1, 11'h7FC);
    clr();
    repeat (40) step(0, 1, 11'h7FC);
    check_gaps(1, 1, 4, 8, "full_7fc");
    check_gaps(0, 1, 4, 8, "half_7fc");
    check_gaps(0, 2, 8, 8, "period_7fc");

    // 305: half-period 1275, period 2550 over 3 periods.
    step(1, 1, 11'h305);
    clr();
    repeat (7700) step(0, 1, 11'h305);
    check_gaps(0, 1, 1275, 7, "half_305");
    check_gaps(0, 2, 2550, 7, "period_305");

    // Switch 7FC->7FE two cycles after a reload.
    step(1, 1, 11'h7FC);
    clr();
    do step(0, 1, 11'h7FC); while (!m_full);
    step(0, 1, 11'h7FC);
    step(0, 1, 11'h7FC);
    @(posedge clk); #2;
    chg0 = chg_n;
    repeat (20) step(0, 1, 11'h7FE);
    @(posedge clk); #2;
    n_cmp++;
    if (chg_n - chg0 != 1) begin
      n_bad++;
      $display("FAIL switch_chg got %0d want 1", chg_n - chg0);
    end
    n_cmp++;
    if (full_q.size() < 6 || full_q[1] - full_q[0] != 4) begin
      n_bad++;
      $display("FAIL switch_interval got %0d want 4",
               full_q.size() > 1 ? full_q[1] - full_q[0] : -1);
    end else begin
      for (int i = 1; i + 1 < full_q.size(); i++) begin
        n_cmp++;
        if (full_q[i+1] - full_q[i] != 2) begin
          n_bad++;
          $display("FAIL switch_gap[%0d] got %0d want 2",
                   i, full_q[i+1] - full_q[i]);
        end
      end
    end

    // Rest while playing, then resume.
    step(1, 1, 11'h7FC);
    repeat (10) step(0, 1, 11'h7FC);
    repeat (12) step(0, 1, 11'h7FF);
    repeat (12) step(0, 1, 11'h7FC);

    // EN every other cycle, then EN low for 10 cycles.
    step(1, 1, 11'h7FC);
    clr();
    for (int i = 0; i < 80; i++) step(0, (i % 2) == 0, 11'h7FC);
    check_gaps(1, 1, 8, 9, "full_half_en");
    check_gaps(0, 1, 8, 9, "half_half_en");
    check_gaps(0, 2, 16, 9, "period_half_en");
    repeat (10) step(0, 0, 11'h7FC);

    // Reset mid-period with CNT=7FD, SPKS=1.
    step(1, 1, 11'h7FC);
    step(0, 1, 11'h7FC);
    step(0, 1, 11'h7FC);
    step(1, 1, 11'h7FC);
    repeat (6) step(0, 1, 11'h7FC);

    // Randomized traffic biased toward short intervals.
    repeat (3000) begin
      case ($urandom_range(0, 5))
        0: rt = 11'h7FF;
        1: rt = 11'h7FE;
        2: rt = 11'h7FD;
        3: rt = 11'h7FC;
        4: rt = 11'h7F0;
        default: rt = W'($urandom_range(1984, 2047));
      endcase
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, rt);
    end

    @(posedge clk); #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_divider.md
TONE_DIVIDER -- requirements
Module: tone_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11, giving the preset and counter width.
REQ-002 The block SHALL treat the all-ones value of WIDTH bits (11'h7FF at default) as the terminal count and the rest code; this document calls it MAXV.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port EN, input, 1 bit: prescaler tick; the counter advances only on cycles with EN=1.
REQ-006 The block SHALL have port TONE, input, WIDTH bits: divider preset from the note-code stage; MAXV means rest.
REQ-007 The block SHALL have port SPKS, output, 1 bit: registered speaker square wave.
REQ-008 The block SHALL have port FULL, output, 1 bit: registered one-cycle pulse on each reload.
REQ-009 The block SHALL have port NOTE_CHG, output, 1 bit: registered one-cycle pulse when a reload latches a TONE different from the previously latched one.
REQ-010 The block SHALL have port REST, output, 1 bit: registered, 1 while the latched tone equals MAXV.

Function
REQ-011 The block SHALL hold internal registers CNT (WIDTH bits) and TONE_L (WIDTH bits, the latched preset).
REQ-012 On an EN=1 cycle with CNT=MAXV (reload), the block SHALL set CNT<=TONE and TONE_L<=TONE, and SHALL set FULL<=1 on the next edge.
REQ-013 On an EN=1 cycle with CNT!=MAXV, the block SHALL set CNT<=CNT+1 (no wrap is possible) and FULL<=0.
REQ-014 On an EN=0 cycle, the block SHALL hold CNT, TONE_L, SPKS and REST, and SHALL drive FULL<=0 and NOTE_CHG<=0.
REQ-015 On reload, the block SHALL set SPKS<=~SPKS if the TONE being loaded !=MAXV, and SPKS<=0 if it equals MAXV.
REQ-016 The block SHALL sample TONE only at reload, so changes between reloads never shorten or stretch the current half-period.
REQ-017 On reload, the block SHALL set NOTE_CHG<=1 if TONE!=TONE_L (old value), else NOTE_CHG<=0; on non-reload cycles NOTE_CHG SHALL be 0.
REQ-018 On reload, the block SHALL set REST<=(TONE==MAXV).
REQ-019 The reload interval SHALL be (MAXV+1-TONE_L) EN ticks, so the SPKS frequency is f_EN/(2*(2^WIDTH-TONE_L)).
REQ-020 With TONE_L=MAXV, CNT SHALL stay at MAXV, a reload SHALL occur on every EN tick, FULL SHALL pulse on each such tick, and SPKS SHALL remain 0, so a new note is picked up on the next EN tick.
REQ-021 The block SHALL have a pipeline latency from a reload-cycle edge to the SPKS/FULL/NOTE_CHG/REST update of exactly one clock.

Reset
REQ-022 With RST=1 at a rising edge, the block SHALL set CNT=MAXV, TONE_L=MAXV, SPKS=0, FULL=0, NOTE_CHG=0 and REST=1, regardless of EN.
REQ-023 RST SHALL take priority over EN and reload; if RST is asserted mid-period, the next EN tick after release SHALL be a reload.

Verification
REQ-024 The bench SHALL cover: RST for 2 cycles, EN=1 constant, TONE=11'h7FC -> first edge after release: FULL=1, SPKS=1, NOTE_CHG=1, REST=0; thereafter FULL every 4 cycles, SPKS period 8 cycles.
REQ-025 The bench SHALL cover: TONE=11'h305, EN=1 -> SPKS half-period 1275 cycles and full period 2550 cycles, measured over 3 periods.
REQ-026 The bench SHALL cover: TONE switched from 11'h7FC to 11'h7FE two cycles after a reload -> the current interval stays 4 cycles, NOTE_CHG pulses once at the next reload, and intervals are then 2 cycles.
REQ-027 The bench SHALL cover: TONE=11'h7FF (rest) while playing -> at the next reload SPKS=0 and REST=1, FULL then pulses every EN tick; returning TONE to 11'h7FC resumes toggling at the following EN tick.
REQ-028 The bench SHALL cover: EN high every other cycle with TONE=11'h7FC -> FULL every 8 cycles and SPKS period 16 cycles; EN held low for 10 cycles -> all outputs frozen, FULL=0.
REQ-029 The bench SHALL cover: RST asserted for 1 cycle with CNT=11'h7FD and SPKS=1 -> next edge CNT=MAXV, SPKS=0, REST=1; the first EN tick after release reloads.
